// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave front end: FSM encodings, BCD constants
// and the MM:SS digit bus.
package microwave_pkg;

  localparam int MMSS_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [MMSS_W-1:0] BCD_ZERO = 4'd0;
  localparam logic [MMSS_W-1:0] BCD_FIVE = 4'd5;
  localparam logic [MMSS_W-1:0] BCD_NINE = 4'd9;

  typedef struct packed {
    logic [MMSS_W-1:0] second_m;
    logic [MMSS_W-1:0] first_m;
    logic [MMSS_W-1:0] second_s;
    logic [MMSS_W-1:0] first_s;
  } mmss_t;

  function automatic logic mmss_is_zero(input mmss_t t);
    return (t == '0);
  endfunction

endpackage

// File: rtl/bcd_mmss_decrement.sv
// Combinational one-second decrement of an MM:SS BCD display with borrow.
// Seconds tens above 5 are not normalised; they simply count down.
module bcd_mmss_decrement
  import microwave_pkg::*;
(
  input  logic [MMSS_W-1:0] first_s_in,
  input  logic [MMSS_W-1:0] second_s_in,
  input  logic [MMSS_W-1:0] first_m_in,
  input  logic [MMSS_W-1:0] second_m_in,
  output logic [MMSS_W-1:0] first_s_out,
  output logic [MMSS_W-1:0] second_s_out,
  output logic [MMSS_W-1:0] first_m_out,
  output logic [MMSS_W-1:0] second_m_out,
  output logic              is_zero_out
);

  always_comb begin
    first_s_out  = first_s_in;
    second_s_out = second_s_in;
    first_m_out  = first_m_in;
    second_m_out = second_m_in;
    if (first_s_in != BCD_ZERO) begin
      first_s_out = first_s_in - 4'd1;
    end else begin
      first_s_out = BCD_NINE;
      if (second_s_in != BCD_ZERO) begin
        second_s_out = second_s_in - 4'd1;
      end else begin
        second_s_out = BCD_FIVE;
        if (first_m_in != BCD_ZERO) begin
          first_m_out = first_m_in - 4'd1;
        end else begin
          first_m_out  = BCD_NINE;
          second_m_out = second_m_in - 4'd1;
        end
      end
    end
  end

  assign is_zero_out = (first_s_out == BCD_ZERO) && (second_s_out == BCD_ZERO) &&
                       (first_m_out == BCD_ZERO) && (second_m_out == BCD_ZERO);

endmodule

// File: rtl/cook_timer.sv
// Microwave countdown front end: keypad entry into an MM:SS BCD display,
// IDLE/RUN/PAUSE control and a prescaled once-per-second countdown.
module cook_timer
  import microwave_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [MMSS_W-1:0] key_digit,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              door_open,
  output logic [MMSS_W-1:0] first_s,
  output logic [MMSS_W-1:0] second_s,
  output logic [MMSS_W-1:0] first_m,
  output logic [MMSS_W-1:0] second_m,
  output logic              running,
  output logic              magnetron_on,
  output logic              done_pulse
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  state_t           state, state_next;
  mmss_t            disp, disp_next, disp_dec;
  logic [PRE_W-1:0] presc, presc_next;
  logic             done_next;
  logic             dec_zero;
  logic             tick;
  logic             key_ok;

  bcd_mmss_decrement u_dec (
    .first_s_in   (disp.first_s),
    .second_s_in  (disp.second_s),
    .first_m_in   (disp.first_m),
    .second_m_in  (disp.second_m),
    .first_s_out  (disp_dec.first_s),
    .second_s_out (disp_dec.second_s),
    .first_m_out  (disp_dec.first_m),
    .second_m_out (disp_dec.second_m),
    .is_zero_out  (dec_zero)
  );

  assign tick   = (presc == PRE_LAST);
  assign key_ok = key_valid && (key_digit <= BCD_NINE);

  always_comb begin
    state_next = state;
    disp_next  = disp;
    presc_next = presc;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clear) begin
          disp_next = '0;
        end else if (key_ok) begin
          disp_next = {disp.first_m, disp.second_s, disp.first_s, key_digit};
        end
        // stop takes priority over start even when nothing is running
        if (!stop && start && !door_open && !mmss_is_zero(disp)) begin
          state_next = ST_RUN;
          presc_next = '0;
        end
      end
      ST_RUN: begin
        // a tick landing on the pause cycle is dropped, prescaler held
        if (stop || door_open) begin
          state_next = ST_PAUSE;
        end else if (tick) begin
          disp_next  = disp_dec;
          presc_next = '0;
          if (dec_zero) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end else begin
          presc_next = presc + PRE_ONE;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_next = ST_IDLE;
          disp_next  = '0;
        end else if (start && !door_open) begin
          state_next = ST_RUN;
          presc_next = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      disp         <= '0;
      presc        <= '0;
      magnetron_on <= 1'b0;
      done_pulse   <= 1'b0;
    end else begin
      state        <= state_next;
      disp         <= disp_next;
      presc        <= presc_next;
      magnetron_on <= (state_next == ST_RUN);
      done_pulse   <= done_next;
    end
  end

  assign running  = (state == ST_RUN);
  assign first_s  = disp.first_s;
  assign second_s = disp.second_s;
  assign first_m  = disp.first_m;
  assign second_m = disp.second_m;

endmodule

// File: tb/tb_cook_timer.sv
// Bench for cook_timer: directed scenarios plus random traffic, every cycle
// scored against a seconds/minutes arithmetic model through an expectation queue.
module tb_cook_timer;

  localparam int TD = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HELD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       door_open = 1'b0;
  logic [3:0] first_s, second_s, first_m, second_m;
  logic       running, magnetron_on, done_pulse;

  cook_timer #(.TICK_DIV(TD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .start        (start),
    .stop         (stop),
    .clear        (clear),
    .door_open    (door_open),
    .first_s      (first_s),
    .second_s     (second_s),
    .first_m      (first_m),
    .second_m     (second_m),
    .running      (running),
    .magnetron_on (magnetron_on),
    .done_pulse   (done_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] disp;
    logic        run;
    logic        mag;
    logic        done;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   door_lvl = 1'b0;

  int m_mode = M_IDLE;
  int m_mm = 0;
  int m_ss = 0;
  int m_cnt = 0;
  bit m_done = 1'b0;

  function automatic logic [15:0] bcd(input int mm, input int ss);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] dut_disp();
    return {second_m, first_m, second_s, first_s};
  endfunction

  function automatic void check(input string name, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_mm = 0;
    m_ss = 0;
    m_cnt = 0;
    m_done = 1'b0;
  endfunction

  // One clock edge of the behaviour, with time held as integer minutes and seconds.
  function automatic void model_step(input bit kv, input int kd, input bit st,
                                     input bit sp, input bit cl, input bit door);
    bit was_zero;
    was_zero = (m_mm == 0) && (m_ss == 0);
    m_done = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (cl) begin
          m_mm = 0;
          m_ss = 0;
        end else if (kv && kd <= 9) begin
          m_mm = (m_mm % 10) * 10 + m_ss / 10;
          m_ss = (m_ss % 10) * 10 + kd;
        end
        if (!sp && st && !door && !was_zero) begin
          m_mode = M_RUN;
          m_cnt = 0;
        end
      end
      M_RUN: begin
        if (sp || door) begin
          m_mode = M_HELD;
        end else begin
          m_cnt++;
          if (m_cnt == TD) begin
            m_cnt = 0;
            if (m_ss > 0) m_ss--;
            else begin
              m_ss = 59;
              m_mm--;
            end
            if (m_mm == 0 && m_ss == 0) begin
              m_mode = M_IDLE;
              m_done = 1'b1;
            end
          end
        end
      end
      default: begin
        if (sp) begin
          m_mode = M_IDLE;
          m_mm = 0;
          m_ss = 0;
        end else if (st && !door) begin
          m_mode = M_RUN;
          m_cnt = 0;
        end
      end
    endcase
  endfunction

  task automatic cyc(input bit kv, input int kd, input bit st, input bit sp, input bit cl);
    exp_t e;
    @(negedge clk);
    key_valid = kv;
    key_digit = 4'(kd);
    start = st;
    stop = sp;
    clear = cl;
    door_open = door_lvl;
    @(posedge clk);
    model_step(kv, kd, st, sp, cl, door_lvl);
    e.disp = bcd(m_mm, m_ss);
    e.run  = (m_mode == M_RUN);
    e.mag  = (m_mode == M_RUN);
    e.done = m_done;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic key(input int d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    key(a); key(b); key(c); key(d);
  endtask

  task automatic go();
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic halt();
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic expect_now(input string name, input logic [15:0] disp, input logic run);
    #1;
    check({name, "_disp"}, dut_disp(), disp);
    check({name, "_running"}, 16'(running), 16'(run));
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("sb_display", dut_disp(), e.disp);
      check("sb_running", 16'(running), 16'(e.run));
      check("sb_magnetron", 16'(magnetron_on), 16'(e.mag));
      check("sb_done", 16'(done_pulse), 16'(e.done));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_disp", dut_disp(), 16'h0000);
    check("rst_running", 16'(running), 16'h0);
    check("rst_magnetron", 16'(magnetron_on), 16'h0);
    check("rst_done", 16'(done_pulse), 16'h0);
    rst_n = 1'b1;
    model_reset();

    // keypad entry, clear, invalid digit
    key(1); key(2); key(3); key(4);
    expect_now("entry", 16'h1234, 1'b0);
    cyc(1'b1, 5, 1'b0, 1'b0, 1'b1);
    expect_now("clear", 16'h0000, 1'b0);
    key(11);
    expect_now("key11", 16'h0000, 1'b0);

    // 00:03 countdown to done
    enter4(0, 0, 0, 3);
    go();
    idle(4);
    expect_now("cd2", 16'h0002, 1'b1);
    idle(4);
    expect_now("cd1", 16'h0001, 1'b1);
    idle(3);
    expect_now("cd1_hold", 16'h0001, 1'b1);
    idle(1);
    #1;
    check("cd0_done", 16'(done_pulse), 16'h1);
    expect_now("cd0", 16'h0000, 1'b0);
    idle(2);

    // borrow cases
    enter4(0, 1, 0, 0); go(); idle(4);
    expect_now("b0100", 16'h0059, 1'b1);
    halt(); halt();
    enter4(1, 0, 0, 0); go(); idle(4);
    expect_now("b1000", 16'h0959, 1'b1);
    halt(); halt();
    enter4(0, 0, 9, 9); go(); idle(4);
    expect_now("b0099", 16'h0098, 1'b1);
    halt(); halt();

    // door interlock
    enter4(0, 0, 0, 5); go(); idle(8);
    door_lvl = 1'b1;
    idle(1);
    #1;
    check("door_mag", 16'(magnetron_on), 16'h0);
    expect_now("door_frozen", 16'h0003, 1'b0);
    go();
    expect_now("door_start_ignored", 16'h0003, 1'b0);
    door_lvl = 1'b0;
    idle(2);
    go(); idle(3);
    expect_now("resume_hold", 16'h0003, 1'b1);
    idle(1);
    expect_now("resume_dec", 16'h0002, 1'b1);
    halt(); halt();

    // tick coinciding with stop is dropped
    enter4(0, 0, 0, 5); go(); idle(3); halt();
    expect_now("tick_drop", 16'h0005, 1'b0);
    halt();

    // stop pauses, second stop cancels
    enter4(0, 0, 1, 0); go(); idle(2); halt(); idle(6);
    expect_now("paused", 16'h0010, 1'b0);
    halt();
    expect_now("cancel", 16'h0000, 1'b0);
    enter4(0, 0, 0, 5);
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    expect_now("start_stop", 16'h0005, 1'b0);

    // start at 00:00 ignored
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    go();
    expect_now("start_zero", 16'h0000, 1'b0);

    // asynchronous reset mid-run
    enter4(0, 0, 0, 3); go(); idle(5);
    expect_now("pre_rst", 16'h0002, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_disp", dut_disp(), 16'h0000);
    check("midrst_running", 16'(running), 16'h0);
    check("midrst_magnetron", 16'(magnetron_on), 16'h0);
    check("midrst_done", 16'(done_pulse), 16'h0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(6);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) door_lvl = ~door_lvl;
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15),
          $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 49) == 0);
    end
    door_lvl = 1'b0;
    idle(2);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
